// File: rtl/note_sequencer_pkg.sv
// Shared constants and state encoding for the note record/playback controller.
// Mode codes are what the outside world sees; states are internal to the FSM.
package note_sequencer_pkg;

    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_RECORD = 2'b01;
    localparam logic [1:0] MODE_PLAY   = 2'b10;

    localparam int NOTE_REST = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RECORD = 3'd1,
        ST_FETCH  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // FETCH, WAIT and HOLD all report as playback.
    function automatic logic [1:0] mode_of(state_e s);
        logic [1:0] m;
        m = MODE_IDLE;
        case (s)
            ST_RECORD: m = MODE_RECORD;
            ST_FETCH,
            ST_WAIT,
            ST_HOLD:   m = MODE_PLAY;
            default:   m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/note_sequencer_ram.sv
// Simple dual-port note store: one write port, one read port.
// With SynchronousRead the read address is registered, so data follows one edge later.
module note_sequencer_ram #(
    parameter int Width           = 8,
    parameter int AWidth          = 6,
    parameter int Depth           = 16,
    parameter int SynchronousRead = 1
) (
    input  logic              clock,
    input  logic              we,
    input  logic [AWidth-1:0] w_address,
    input  logic [Width-1:0]  data_in,
    input  logic [AWidth-1:0] r_address,
    output logic [Width-1:0]  data_out
);

    logic [Width-1:0] mem [Depth];

    // Contents are deliberately never reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[w_address] <= data_in;
        end
    end

    if (SynchronousRead != 0) begin : g_sync_read
        logic [AWidth-1:0] r_address_q;

        always_ff @(posedge clock) begin
            r_address_q <= r_address;
        end

        assign data_out = mem[r_address_q];
    end else begin : g_async_read
        assign data_out = mem[r_address];
    end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback controller: records keyboard notes into the store and replays
// them one entry per beat. Record and playback never overlap, so RAM ports never collide.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int Width  = 8,
    parameter int AWidth = 6,
    parameter int Depth  = 64,
    parameter int Loop   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              record_start,
    input  logic              play_start,
    input  logic              stop,
    input  logic              note_valid,
    input  logic [Width-1:0]  note_in,
    input  logic              beat_tick,
    output logic [Width-1:0]  note_out,
    output logic              note_active,
    output logic [AWidth:0]   count,
    output logic              full,
    output logic [1:0]        mode
);

    localparam logic [AWidth:0] DEPTH_COUNT = (AWidth+1)'(Depth);

    state_e              state_q, state_d;
    logic [AWidth:0]     count_q, count_d;
    logic [AWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0]    note_out_q, note_out_d;
    logic                note_active_q, note_active_d;

    logic                full_w;
    logic                play_ok;
    logic                cmd_any;
    logic                ram_we;
    logic [Width-1:0]    ram_data_out;

    assign full_w  = (count_q == DEPTH_COUNT);
    assign play_ok = play_start && (count_q != '0);
    assign cmd_any = stop || record_start || play_ok;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            note_out_q    <= Width'(NOTE_REST);
            note_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            note_out_q    <= note_out_d;
            note_active_q <= note_active_d;
        end
    end

    // Commands override whatever the current state is doing, in priority order.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        note_out_d    = note_out_q;
        note_active_d = note_active_q;

        if (stop) begin
            state_d       = ST_IDLE;
            note_out_d    = Width'(NOTE_REST);
            note_active_d = 1'b0;
        end else if (record_start) begin
            state_d       = ST_RECORD;
            count_d       = '0;
            wr_ptr_d      = '0;
            note_out_d    = Width'(NOTE_REST);
            note_active_d = 1'b0;
        end else if (play_ok) begin
            state_d  = ST_FETCH;
            rd_ptr_d = '0;
        end else begin
            case (state_q)
                ST_RECORD: begin
                    if (ram_we) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        count_d  = count_q + 1'b1;
                    end
                end
                ST_FETCH: state_d = ST_WAIT;
                ST_WAIT: begin
                    note_out_d    = ram_data_out;
                    note_active_d = 1'b1;
                    state_d       = ST_HOLD;
                end
                ST_HOLD: begin
                    if (beat_tick) begin
                        if (({1'b0, rd_ptr_q} + 1'b1) < count_q) begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            state_d  = ST_FETCH;
                        end else if (Loop != 0) begin
                            rd_ptr_d = '0;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d       = ST_IDLE;
                            note_out_d    = Width'(NOTE_REST);
                            note_active_d = 1'b0;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A note coinciding with any honoured command is dropped rather than half-recorded.
    always_comb begin
        mode   = mode_of(state_q);
        ram_we = (state_q == ST_RECORD) && note_valid && !full_w && !cmd_any;
    end

    note_sequencer_ram #(
        .Width           (Width),
        .AWidth          (AWidth),
        .Depth           (Depth),
        .SynchronousRead (1)
    ) u_store (
        .clock     (clock),
        .we        (ram_we),
        .w_address (wr_ptr_q),
        .data_in   (note_in),
        .r_address (rd_ptr_q),
        .data_out  (ram_data_out)
    );

    assign note_out    = note_out_q;
    assign note_active = note_active_q;
    assign count       = count_q;
    assign full        = full_w;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a looping and a one-shot instance share the same stimulus
// and are compared every cycle against a note-list model, plus directed literal checks.
module tb_note_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       record_start = 1'b0;
    logic       play_start = 1'b0;
    logic       stop = 1'b0;
    logic       note_valid = 1'b0;
    logic [7:0] note_in = 8'h00;
    logic       beat_tick = 1'b0;

    logic [7:0] note_l, note_o;
    logic       active_l, active_o;
    logic [6:0] count_l, count_o;
    logic       full_l, full_o;
    logic [1:0] mode_l, mode_o;

    int vectors = 0;
    int miscompares = 0;

    // Model: per instance, the recorded list, which entry is playing and how many
    // edges remain until it reaches the output.
    int         m_mode   [2];
    int         m_count  [2];
    logic [7:0] m_mem    [2][64];
    int         m_idx    [2];
    int         m_lat    [2];
    logic [7:0] m_note   [2];
    logic       m_active [2];

    note_sequencer #(.Width(8), .AWidth(6), .Depth(64), .Loop(1)) dut_loop (
        .clock(clock), .reset(reset), .record_start(record_start), .play_start(play_start),
        .stop(stop), .note_valid(note_valid), .note_in(note_in), .beat_tick(beat_tick),
        .note_out(note_l), .note_active(active_l), .count(count_l), .full(full_l), .mode(mode_l)
    );

    note_sequencer #(.Width(8), .AWidth(6), .Depth(64), .Loop(0)) dut_once (
        .clock(clock), .reset(reset), .record_start(record_start), .play_start(play_start),
        .stop(stop), .note_valid(note_valid), .note_in(note_in), .beat_tick(beat_tick),
        .note_out(note_o), .note_active(active_o), .count(count_o), .full(full_o), .mode(mode_o)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic model_step(input int k);
        bit loop_en;
        loop_en = (k == 0);
        if (reset) begin
            m_mode[k] = 0; m_count[k] = 0; m_idx[k] = 0; m_lat[k] = 0;
            m_note[k] = 8'h00; m_active[k] = 1'b0;
        end else if (stop) begin
            m_mode[k] = 0; m_note[k] = 8'h00; m_active[k] = 1'b0; m_lat[k] = 0;
        end else if (record_start) begin
            m_mode[k] = 1; m_count[k] = 0; m_note[k] = 8'h00; m_active[k] = 1'b0; m_lat[k] = 0;
        end else if (play_start && m_count[k] > 0) begin
            m_mode[k] = 2; m_idx[k] = 0; m_lat[k] = 2;
        end else if (m_mode[k] == 1) begin
            if (note_valid && m_count[k] < 64) begin
                m_mem[k][m_count[k]] = note_in;
                m_count[k]++;
            end
        end else if (m_mode[k] == 2) begin
            if (m_lat[k] > 0) begin
                m_lat[k]--;
                if (m_lat[k] == 0) begin
                    m_note[k] = m_mem[k][m_idx[k]];
                    m_active[k] = 1'b1;
                end
            end else if (beat_tick) begin
                if (m_idx[k] + 1 < m_count[k]) begin
                    m_idx[k]++; m_lat[k] = 2;
                end else if (loop_en) begin
                    m_idx[k] = 0; m_lat[k] = 2;
                end else begin
                    m_mode[k] = 0; m_note[k] = 8'h00; m_active[k] = 1'b0;
                end
            end
        end
    endtask

    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < 2; k++) model_step(k);
    end

    task automatic compare_dut(input int k, input logic [7:0] no, input logic na,
                               input logic [6:0] cnt, input logic fl, input logic [1:0] md);
        check_output($sformatf("dut%0d.note_out", k), 32'(no), 32'(m_note[k]));
        check_output($sformatf("dut%0d.note_active", k), 32'(na), 32'(m_active[k]));
        check_output($sformatf("dut%0d.count", k), 32'(cnt), 32'(m_count[k]));
        check_output($sformatf("dut%0d.full", k), 32'(fl), 32'(m_count[k] == 64));
        check_output($sformatf("dut%0d.mode", k), 32'(md), 32'(m_mode[k]));
    endtask

    always @(posedge clock) begin
        #1;
        compare_dut(0, note_l, active_l, count_l, full_l, mode_l);
        compare_dut(1, note_o, active_o, count_o, full_o, mode_o);
    end

    task automatic apply_stimulus(input logic rs, input logic ps, input logic st,
                                  input logic nv, input logic [7:0] ni, input logic bt);
        @(negedge clock);
        record_start = rs;
        play_start   = ps;
        stop         = st;
        note_valid   = nv;
        note_in      = ni;
        beat_tick    = bt;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] exp_loop [4];
        logic [7:0] exp_once [4];
        exp_loop = '{8'h22, 8'h33, 8'h11, 8'h22};
        exp_once = '{8'h22, 8'h33, 8'h00, 8'h00};

        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle(1);
        check_output("reset.count", 32'(count_l), 32'd0);
        check_output("reset.mode", 32'(mode_l), 32'd0);
        check_output("reset.note_out", 32'(note_l), 32'd0);
        check_output("reset.note_active", 32'(active_l), 32'd0);
        check_output("reset.full", 32'(full_l), 32'd0);

        apply_stimulus(1, 0, 0, 0, 8'h00, 0);
        apply_stimulus(0, 0, 0, 1, 8'h11, 0);
        apply_stimulus(0, 0, 0, 1, 8'h22, 0);
        apply_stimulus(0, 0, 0, 1, 8'h33, 0);
        apply_stimulus(0, 0, 1, 0, 8'h00, 0);
        idle(1);
        check_output("rec3.count", 32'(count_l), 32'd3);
        check_output("rec3.mode", 32'(mode_l), 32'd0);

        apply_stimulus(0, 1, 0, 0, 8'h00, 0);
        idle(3);
        check_output("play.first_note_loop", 32'(note_l), 32'h11);
        check_output("play.first_note_once", 32'(note_o), 32'h11);
        check_output("play.active", 32'(active_l), 32'd1);
        check_output("play.mode", 32'(mode_l), 32'd2);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(0, 0, 0, 0, 8'h00, 1);
            idle(3);
            check_output($sformatf("beat%0d.loop_note", i), 32'(note_l), 32'(exp_loop[i]));
            check_output($sformatf("beat%0d.loop_active", i), 32'(active_l), 32'd1);
            check_output($sformatf("beat%0d.once_note", i), 32'(note_o), 32'(exp_once[i]));
            check_output($sformatf("beat%0d.once_active", i), 32'(active_o), 32'(i < 2));
            check_output($sformatf("beat%0d.once_mode", i), 32'(mode_o), (i < 2) ? 32'd2 : 32'd0);
            idle(4);
        end
        apply_stimulus(0, 0, 1, 0, 8'h00, 0);
        idle(1);

        apply_stimulus(0, 1, 0, 0, 8'h00, 0);
        idle(4);
        apply_stimulus(1, 1, 1, 0, 8'h00, 0);
        idle(1);
        check_output("allcmd.mode", 32'(mode_l), 32'd0);
        check_output("allcmd.count", 32'(count_l), 32'd3);
        check_output("allcmd.note_out", 32'(note_l), 32'd0);
        apply_stimulus(1, 0, 0, 0, 8'h00, 0);
        apply_stimulus(0, 0, 1, 0, 8'h00, 0);
        apply_stimulus(0, 1, 0, 0, 8'h00, 0);
        idle(2);
        check_output("emptyplay.mode", 32'(mode_l), 32'd0);
        check_output("emptyplay.count", 32'(count_l), 32'd0);

        apply_stimulus(1, 0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 64; i++) apply_stimulus(0, 0, 0, 1, 8'(i + 1), 0);
        idle(1);
        check_output("fill64.count", 32'(count_l), 32'd64);
        check_output("fill64.full", 32'(full_l), 32'd1);
        apply_stimulus(0, 0, 0, 1, 8'hEE, 0);
        idle(1);
        check_output("fill65.count", 32'(count_l), 32'd64);
        check_output("fill65.mode", 32'(mode_l), 32'd1);
        apply_stimulus(0, 0, 1, 0, 8'h00, 0);
        apply_stimulus(0, 1, 0, 0, 8'h00, 0);
        idle(2);
        for (int b = 1; b < 64; b++) begin
            apply_stimulus(0, 0, 0, 0, 8'h00, 1);
            idle(2);
        end
        idle(1);
        check_output("entry63.loop", 32'(note_l), 32'h40);
        check_output("entry63.once", 32'(note_o), 32'h40);

        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check_output("asyncrst.note_out", 32'(note_l), 32'd0);
        check_output("asyncrst.note_active", 32'(active_l), 32'd0);
        check_output("asyncrst.mode", 32'(mode_l), 32'd0);
        check_output("asyncrst.count", 32'(count_l), 32'd0);
        check_output("asyncrst.once_count", 32'(count_o), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int n = 0; n < 3000; n++) begin
            apply_stimulus($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5,
                           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 45,
                           8'($urandom), $urandom_range(0, 99) < 30);
        end
        apply_stimulus(0, 0, 1, 0, 8'h00, 0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
